axis_adc_acq_ctrl: RTL and testbench

AXIS_ADC_ACQ_CTRL -- requirements
Module: axis_adc_acq_ctrl

---
 rtl/adc_acq_pkg.sv | 17 +
 rtl/axis_adc_acq_ctrl_if.sv | 20 ++
 rtl/axis_acq_outreg.sv | 72 +++++++
 rtl/axis_adc_acq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_axis_adc_acq_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition controller.
// Holds the default data/counter widths and the FSM state encodings that
// software reads back through out_state.
package adc_acq_pkg;

    localparam int unsigned DefAxisDataWidth = 32;
    localparam int unsigned DefCntWidth      = 16;
    localparam int unsigned DefDecimWidth    = 8;

    // FSM state encodings; the values are visible on out_state.
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StArmed   = 3'd1;
    localparam logic [2:0] StDelay   = 3'd2;
    localparam logic [2:0] StCapture = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

endpackage

// File: rtl/axis_adc_acq_ctrl_if.sv
// AXI-Stream style bundle used for the ADC input and the captured output.
// Ports (signals):
//   valid, data, last : driven by the master
//   ready             : driven by the slave
// The ADC side carries no end-of-packet marker, so the slave view omits last.
interface axis_adc_acq_ctrl_if
    import adc_acq_pkg::*;
#(
    parameter int unsigned DataWidth = DefAxisDataWidth
);

    logic                 valid;
    logic [DataWidth-1:0] data;
    logic                 last;
    logic                 ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/axis_acq_outreg.sv
// Single-entry output register for captured samples.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (discards any beat)
//   load_i       : a sample is due this cycle; data_i/last_i describe it
//   clr_ovf_i    : clear the sticky overflow flag
//   free_o       : register will be empty after this edge if nothing loads
//   m_axis       : captured stream (valid/data/last held until ready)
//   overflow_o   : sticky, set when a due sample finds the register blocked
module axis_acq_outreg
    import adc_acq_pkg::*;
#(
    parameter int unsigned DataWidth = DefAxisDataWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 last_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 clr_ovf_i,
    output logic                 free_o,
    axis_adc_acq_ctrl_if.master  m_axis,
    output logic                 overflow_o
);

    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 ovf_q, ovf_d;
    logic [DataWidth-1:0] data_q, data_d;

    assign free_o = ~valid_q | m_axis.ready;

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        if (load_i && free_o) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (m_axis.ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        // A blocked sample is lost; the FSM still counts it toward length.
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end else if (load_i && !free_o) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign m_axis.valid = valid_q;
    assign m_axis.data  = data_q;
    assign m_axis.last  = last_q;
    assign overflow_o   = ovf_q;

endmodule

// File: rtl/axis_adc_acq_ctrl.sv
// Triggered ADC acquisition controller.
// Arm latches delay/length/decimation; a trigger rising edge starts a
// post-trigger delay, then decimated samples are captured into a single-entry
// output register until length samples have been counted.
// Ports:
//   in_adc_clk, in_rst      : clock, synchronous active-high reset
//   in_arm, in_abort        : start request (IDLE only), abort level
//   in_trig                 : trigger level, synchronous to in_adc_clk
//   in_delay/length/decim   : acquisition parameters, latched at arm
//   s_axis                  : ADC sample stream (always accepted)
//   m_axis                  : captured sample stream
//   out_busy/done/overflow  : status; out_state is the raw FSM state
module axis_adc_acq_ctrl
    import adc_acq_pkg::*;
#(
    parameter int unsigned INT_AXIS_DATA_WIDTH = DefAxisDataWidth,
    parameter int unsigned INT_CNT_WIDTH       = DefCntWidth,
    parameter int unsigned INT_DECIM_WIDTH     = DefDecimWidth
) (
    input  logic                       in_adc_clk,
    input  logic                       in_rst,
    input  logic                       in_arm,
    input  logic                       in_abort,
    input  logic                       in_trig,
    input  logic [INT_CNT_WIDTH-1:0]   in_delay,
    input  logic [INT_CNT_WIDTH-1:0]   in_length,
    input  logic [INT_DECIM_WIDTH-1:0] in_decim,
    axis_adc_acq_ctrl_if.slave         s_axis,
    axis_adc_acq_ctrl_if.master        m_axis,
    output logic                       out_busy,
    output logic                       out_done,
    output logic                       out_overflow,
    output logic [2:0]                 out_state
);

    localparam logic [INT_CNT_WIDTH-1:0]   CntOne   = {{(INT_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [INT_DECIM_WIDTH-1:0] DecimOne = {{(INT_DECIM_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]                 state_q, state_d;
    logic                       trig_q;
    logic                       done_q, done_d;
    logic [INT_CNT_WIDTH-1:0]   delay_q, delay_d;
    logic [INT_CNT_WIDTH-1:0]   length_q, length_d;
    logic [INT_DECIM_WIDTH-1:0] decim_q, decim_d;
    logic [INT_CNT_WIDTH-1:0]   delay_cnt_q, delay_cnt_d;
    logic [INT_CNT_WIDTH-1:0]   sample_cnt_q, sample_cnt_d;
    logic [INT_DECIM_WIDTH-1:0] decim_cnt_q, decim_cnt_d;

    logic take, take_last, clr_ovf, out_free, trig_edge;

    // The ADC reader cannot be back-pressured; samples are dropped instead.
    assign s_axis.ready = 1'b1;
    assign trig_edge    = in_trig & ~trig_q;

    always_comb begin
        state_d      = state_q;
        delay_d      = delay_q;
        length_d     = length_q;
        decim_d      = decim_q;
        delay_cnt_d  = delay_cnt_q;
        sample_cnt_d = sample_cnt_q;
        decim_cnt_d  = decim_cnt_q;
        done_d       = 1'b0;
        take         = 1'b0;
        take_last    = 1'b0;
        clr_ovf      = 1'b0;
        if (in_abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_arm) begin
                        state_d      = StArmed;
                        delay_d      = in_delay;
                        length_d     = in_length;
                        decim_d      = in_decim;
                        delay_cnt_d  = '0;
                        sample_cnt_d = '0;
                        decim_cnt_d  = '0;
                        clr_ovf      = 1'b1;
                    end
                end
                StArmed: begin
                    if (trig_edge) begin
                        state_d = (delay_q == '0) ? StCapture : StDelay;
                    end
                end
                StDelay: begin
                    // delay_q >= 1 here, so delay_q - 1 cannot wrap.
                    if (delay_cnt_q == delay_q - CntOne) begin
                        state_d = StCapture;
                    end else begin
                        delay_cnt_d = delay_cnt_q + CntOne;
                    end
                end
                StCapture: begin
                    if (length_q == '0) begin
                        state_d = StDone;
                    end else if (s_axis.valid) begin
                        decim_cnt_d = (decim_cnt_q == decim_q) ? '0 : decim_cnt_q + DecimOne;
                        if (decim_cnt_q == '0) begin
                            take      = 1'b1;
                            take_last = (sample_cnt_q == length_q - CntOne);
                            if (take_last) begin
                                state_d = StDone;
                            end else begin
                                sample_cnt_d = sample_cnt_q + CntOne;
                            end
                        end
                    end
                end
                StDone: begin
                    // Register empties at this edge, so done lands as busy drops.
                    if (out_free) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge in_adc_clk) begin
        if (in_rst) begin
            state_q      <= StIdle;
            trig_q       <= 1'b0;
            done_q       <= 1'b0;
            delay_q      <= '0;
            length_q     <= '0;
            decim_q      <= '0;
            delay_cnt_q  <= '0;
            sample_cnt_q <= '0;
            decim_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            trig_q       <= in_trig;
            done_q       <= done_d;
            delay_q      <= delay_d;
            length_q     <= length_d;
            decim_q      <= decim_d;
            delay_cnt_q  <= delay_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            decim_cnt_q  <= decim_cnt_d;
        end
    end

    axis_acq_outreg #(
        .DataWidth (INT_AXIS_DATA_WIDTH)
    ) u_outreg (
        .clk_i      (in_adc_clk),
        .rst_i      (in_rst),
        .load_i     (take),
        .last_i     (take_last),
        .data_i     (s_axis.data),
        .clr_ovf_i  (clr_ovf),
        .free_o     (out_free),
        .m_axis     (m_axis),
        .overflow_o (out_overflow)
    );

    assign out_busy  = (state_q != StIdle);
    assign out_done  = done_q;
    assign out_state = state_q;

endmodule

// File: tb/tb_axis_adc_acq_ctrl.sv
module tb_axis_adc_acq_ctrl;
    import adc_acq_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 16;
    localparam int unsigned DCW = 8;

    logic          clk = 1'b0;
    logic          rst, arm, abort, trig;
    logic [CW-1:0] dly, len;
    logic [DCW-1:0] dec;
    logic          busy, done, ovf;
    logic [2:0]    st;

    axis_adc_acq_ctrl_if #(.DataWidth(DW)) s_if ();
    axis_adc_acq_ctrl_if #(.DataWidth(DW)) m_if ();

    axis_adc_acq_ctrl #(
        .INT_AXIS_DATA_WIDTH (DW),
        .INT_CNT_WIDTH       (CW),
        .INT_DECIM_WIDTH     (DCW)
    ) dut (
        .in_adc_clk   (clk),
        .in_rst       (rst),
        .in_arm       (arm),
        .in_abort     (abort),
        .in_trig      (trig),
        .in_delay     (dly),
        .in_length    (len),
        .in_decim     (dec),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .out_busy     (busy),
        .out_done     (done),
        .out_overflow (ovf),
        .out_state    (st)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    int valid_pct = 100;
    int ready_pct = 100;

    // Per-cycle record of what the bench drove.
    logic [DW-1:0] data_at [int];
    bit            val_at  [int];
    bit            rdy_at  [int];

    // What the monitor saw.
    logic [DW-1:0] got_data [$];
    bit            got_last [$];
    int            got_cyc  [$];
    int            done_cyc [$];
    bit            done_busy [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stimulus driver for the ADC stream and downstream ready.
    initial begin
        s_if.valid = 1'b1;
        s_if.data  = '0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            s_if.data  = $urandom;
            s_if.valid = (int'($urandom_range(99)) < valid_pct);
            m_if.ready = (int'($urandom_range(99)) < ready_pct);
            data_at[cyc] = s_if.data;
            val_at[cyc]  = s_if.valid;
            rdy_at[cyc]  = m_if.ready;
        end
    end

    // Monitor: handshakes, done pulses, and output stability while stalled.
    bit            hold = 1'b0;
    bit            prst = 1'b1;
    logic [DW-1:0] hdata;
    bit            hlast;
    initial begin
        forever begin
            @(negedge clk);
            if (hold && !prst) begin
                chk("hold_valid", m_if.valid, 1);
                chk("hold_data", m_if.data, hdata);
                chk("hold_last", m_if.last, hlast);
            end
            if (m_if.valid === 1'b1 && m_if.ready === 1'b1) begin
                got_data.push_back(m_if.data);
                got_last.push_back(m_if.last);
                got_cyc.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cyc.push_back(cyc);
                done_busy.push_back(busy);
            end
            hold  = (m_if.valid === 1'b1) && (m_if.ready === 1'b0);
            hdata = m_if.data;
            hlast = m_if.last;
            prst  = rst;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Arms the block and produces the trigger edge; t is the trigger cycle.
    task automatic start_acq(input int d, input int l, input int m, input bit pre_high,
                             output int t);
        got_data.delete(); got_last.delete(); got_cyc.delete();
        done_cyc.delete(); done_busy.delete();
        trig = pre_high;
        step(1);
        dly = d[CW-1:0];
        len = l[CW-1:0];
        dec = m[DCW-1:0];
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        dly = CW'($urandom);
        len = CW'($urandom);
        dec = DCW'($urandom);
        if (pre_high) begin
            step(3);
            chk("prehigh_armed", st, StArmed);
            trig = 1'b0;
            step(1);
        end
        trig = 1'b1;
        t = cyc;
        step(1);
        arm = 1'b1;  // must be ignored outside IDLE
        step(1);
        arm = 1'b0;
    endtask

    task automatic finish_acq();
        int guard = 0;
        while (done_cyc.size() == 0 && guard < 2000) begin
            trig = 1'($urandom);
            step(1);
            guard++;
        end
        chk("done_seen", done_cyc.size() != 0, 1);
        trig = 1'b0;
        step(2);
    endtask

    // Reference model: walk the recorded inputs from the first capture cycle.
    task automatic check_run(input string tag, input int t, input int d, input int l,
                             input int m);
        int            c, vcnt, taken, edone;
        bit            occ, eovf;
        logic [DW-1:0] ed [$];
        bit            el [$];
        c = t + 1 + d;
        vcnt = 0; taken = 0; occ = 1'b0; eovf = 1'b0;
        if (l == 0) c++;
        while (taken < l && c < t + 20000) begin
            if (val_at[c] && (vcnt % (m + 1)) == 0) begin
                taken++;
                if (occ && !rdy_at[c]) begin
                    eovf = 1'b1;
                end else begin
                    occ = 1'b1;
                    ed.push_back(data_at[c]);
                    el.push_back(taken == l);
                end
            end else if (occ && rdy_at[c]) begin
                occ = 1'b0;
            end
            if (val_at[c]) vcnt++;
            c++;
        end
        while (occ && !rdy_at[c] && c < t + 20000) c++;
        edone = c + 1;
        chk({tag, "_beats"}, got_data.size(), ed.size());
        for (int i = 0; i < ed.size() && i < got_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_data[i], ed[i]);
            chk($sformatf("%s_last%0d", tag, i), got_last[i], el[i]);
        end
        chk({tag, "_ndone"}, done_cyc.size(), 1);
        chk({tag, "_done_cyc"}, (done_cyc.size() > 0) ? done_cyc[0] : -1, edone);
        chk({tag, "_done_busy"}, (done_busy.size() > 0) ? done_busy[0] : 1'b1, 0);
        chk({tag, "_ovf"}, ovf, eovf);
        chk({tag, "_idle"}, st, StIdle);
    endtask

    initial begin
        int t;
        int d, l, m;
        rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
        dly = '0; len = '0; dec = '0;
        step(3);
        @(negedge clk);
        chk("rst_state", st, StIdle);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_valid", m_if.valid, 0);
        chk("rst_last", m_if.last, 0);
        chk("rst_data", m_if.data, 0);
        chk("s_ready", s_if.ready, 1);
        step(1);
        rst = 1'b0;
        step(2);

        // Scenario 1: delay 3, length 4, no decimation.
        valid_pct = 100; ready_pct = 100;
        start_acq(3, 4, 0, 1'b0, t);
        finish_acq();
        check_run("s1", t, 3, 4, 0);
        chk("s1_first_beat_cyc", (got_cyc.size() > 0) ? got_cyc[0] : -1, t + 5);
        chk("s1_done_after_last",
            (got_cyc.size() > 3 && done_cyc.size() > 0) ? done_cyc[0] - got_cyc[3] : -1, 1);

        // Scenario 2: decimation by 3, length 3, no delay.
        start_acq(0, 3, 2, 1'b0, t);
        finish_acq();
        check_run("s2", t, 0, 3, 2);
        chk("s2_samp6", (got_data.size() > 2) ? got_data[2] : '0, data_at[t + 7]);
        chk("s2_last6", (got_last.size() > 2) ? got_last[2] : 1'b0, 1);

        // Scenario 3: ready held low for the whole capture.
        ready_pct = 0;
        start_acq(0, 5, 0, 1'b0, t);
        step(t + 9 - cyc);
        chk("s3_in_done", st, StDone);
        chk("s3_pending", m_if.valid, 1);
        chk("s3_ovf", ovf, 1);
        chk("s3_no_done", done_cyc.size(), 0);
        ready_pct = 100;
        finish_acq();
        check_run("s3", t, 0, 5, 0);

        // Scenario 4: trigger already high at arm.
        start_acq(2, 3, 1, 1'b1, t);
        finish_acq();
        check_run("s4", t, 2, 3, 1);

        // Scenario 6: zero length.
        start_acq(1, 0, 0, 1'b0, t);
        finish_acq();
        check_run("s6", t, 1, 0, 0);

        // Randomized runs with gappy valid and ready.
        valid_pct = 80; ready_pct = 60;
        for (int i = 0; i < 6; i++) begin
            d = int'($urandom_range(12));
            l = int'($urandom_range(10));
            m = int'($urandom_range(3));
            start_acq(d, l, m, 1'($urandom), t);
            finish_acq();
            check_run($sformatf("rnd%0d", i), t, d, l, m);
        end

        // Scenario 5a: abort after two samples with a beat pending.
        valid_pct = 100; ready_pct = 0;
        start_acq(0, 8, 0, 1'b0, t);
        step(1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort_state", st, StIdle);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pending", m_if.valid, 1);
        chk("abort_pend_data", m_if.data, data_at[t + 1]);
        ready_pct = 100;
        step(10);
        chk("abort_beats", got_data.size(), 1);
        chk("abort_beat_data", (got_data.size() > 0) ? got_data[0] : '0, data_at[t + 1]);
        chk("abort_no_done", done_cyc.size(), 0);
        chk("abort_drained", m_if.valid, 0);

        // Scenario 5b: reset at the same point.
        ready_pct = 0;
        start_acq(0, 8, 0, 1'b0, t);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mrst_state", st, StIdle);
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", m_if.valid, 0);
        chk("mrst_last", m_if.last, 0);
        chk("mrst_data", m_if.data, 0);
        chk("mrst_ovf", ovf, 0);
        chk("mrst_done", done, 0);
        ready_pct = 100;

        // Abort beats arm in the same cycle.
        abort = 1'b1;
        arm   = 1'b1;
        step(1);
        abort = 1'b0;
        arm   = 1'b0;
        chk("abort_arm_state", st, StIdle);
        step(1);
        chk("abort_arm_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
